// File: rtl/a2d_pkg.sv
// Shared types and constants for the round-robin ADC128S front end and its SPI engine.
package a2d_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        GAP,
        READ
    } a2d_state_t;

    // rr_idx 0..3 selects ADC channels 0,1,3,4 (battery, current, brake, torque)
    localparam logic [2:0] CHNL_LUT [4] = '{3'd0, 3'd1, 3'd3, 3'd4};

    localparam logic [4:0] SCLK_DIV_PRELOAD = 5'b10111;

    localparam int TMR_W_FAST = 8;
    localparam int TMR_W_SLOW = 14;

    function automatic logic [15:0] cmd_frame(input logic [2:0] chnl);
        return {2'b00, chnl, 11'h000};
    endfunction

endpackage

// File: rtl/spi_xfer16.sv
// 16-bit SPI master, mode 3, SCLK = clk/32; one frame per wrt, done flags the back porch cycle.
module spi_xfer16
    import a2d_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] wt_data,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    logic        busy_reg;
    logic [4:0]  div_reg;
    logic [4:0]  bit_cnt_reg;
    logic [15:0] tx_reg;
    logic [15:0] rx_reg;
    logic        ss_n_reg;

    logic sclk_rise;
    logic sclk_fall;
    logic back_porch;

    assign sclk_rise  = busy_reg && (div_reg == 5'b01111);
    assign sclk_fall  = busy_reg && (div_reg == 5'b11111);
    // The fall following the 16th sample only closes the frame; nothing shifts on it.
    assign back_porch = sclk_fall && (bit_cnt_reg == 5'd16);

    assign SCLK    = div_reg[4];
    assign SS_n    = ss_n_reg;
    assign MOSI    = tx_reg[15];
    assign rd_data = rx_reg;
    assign done    = back_porch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg    <= 1'b0;
            div_reg     <= SCLK_DIV_PRELOAD;
            bit_cnt_reg <= '0;
            tx_reg      <= '0;
            rx_reg      <= '0;
            ss_n_reg    <= 1'b1;
        end else if (!busy_reg) begin
            if (wrt) begin
                busy_reg    <= 1'b1;
                ss_n_reg    <= 1'b0;
                div_reg     <= SCLK_DIV_PRELOAD;
                bit_cnt_reg <= '0;
                tx_reg      <= wt_data;
            end
        end else if (back_porch) begin
            // div stays at all-ones so SCLK idles high
            busy_reg <= 1'b0;
            ss_n_reg <= 1'b1;
        end else begin
            div_reg <= div_reg + 5'd1;
            if (sclk_rise) begin
                rx_reg      <= {rx_reg[14:0], MISO};
                bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
            // The first fall precedes any rise, so the MSB must stay put through it
            if (sclk_fall && (bit_cnt_reg != 5'd0)) begin
                tx_reg <= {tx_reg[14:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/a2d_round_robin.sv
// Periodically converts ADC channels 0,1,3,4 round-robin and holds the latest 12-bit result of each.
module a2d_round_robin
    import a2d_pkg::*;
#(
    parameter bit FAST_SIM = 1'b0
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic [11:0] batt,
    output logic [11:0] curr,
    output logic [11:0] brake,
    output logic [11:0] torque
);

    localparam int TMR_W = FAST_SIM ? TMR_W_FAST : TMR_W_SLOW;

    logic [TMR_W-1:0] timer_reg;
    logic             conv_req;
    logic [1:0]       rr_idx_reg;
    a2d_state_t       state_reg;
    a2d_state_t       state_next;
    logic             wrt_reg;
    logic             wrt_next;
    logic             load;

    logic             spi_done;
    logic [15:0]      spi_rd_data;
    logic [15:0]      spi_wt_data;
    logic [3:0]       unused_rx_hi;

    assign conv_req     = &timer_reg;
    assign unused_rx_hi = spi_rd_data[15:12];

    // wrt is high for the first CMD cycle (command) and for the GAP cycle (read frame)
    assign spi_wt_data = (state_reg == CMD) ? cmd_frame(CHNL_LUT[rr_idx_reg]) : 16'h0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_reg <= '0;
        end else begin
            timer_reg <= timer_reg + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            wrt_reg    <= 1'b0;
            rr_idx_reg <= 2'd0;
        end else begin
            state_reg <= state_next;
            wrt_reg   <= wrt_next;
            if (load) begin
                rr_idx_reg <= rr_idx_reg + 2'd1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        wrt_next   = 1'b0;
        load       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (conv_req) begin
                    state_next = CMD;
                    wrt_next   = 1'b1;
                end
            end
            CMD: begin
                // done coincides with the SS_n rise; launching now gives a single-clk gap
                if (spi_done) begin
                    state_next = GAP;
                    wrt_next   = 1'b1;
                end
            end
            GAP: begin
                state_next = READ;
            end
            READ: begin
                if (spi_done) begin
                    state_next = IDLE;
                    load       = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    spi_xfer16 u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt_reg),
        .wt_data (spi_wt_data),
        .done    (spi_done),
        .rd_data (spi_rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_result
            logic [11:0] value_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    value_reg <= '0;
                end else if (load && (rr_idx_reg == 2'(gi))) begin
                    value_reg <= spi_rd_data[11:0];
                end
            end
        end
    endgenerate

    assign batt   = g_result[0].value_reg;
    assign curr   = g_result[1].value_reg;
    assign brake  = g_result[2].value_reg;
    assign torque = g_result[3].value_reg;

endmodule

// File: tb/tb_a2d_round_robin.sv
// Directed bench for a2d_round_robin with a behavioural ADC128S model and SPI timing monitor.
module tb_a2d_round_robin;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        miso = 1'b0;
    logic        ss_n;
    logic        sclk;
    logic        mosi;
    logic [11:0] batt;
    logic [11:0] curr;
    logic [11:0] brake;
    logic [11:0] torque;

    int n_checks = 0;
    int n_fail   = 0;

    a2d_round_robin #(.FAST_SIM(1'b1)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .MISO   (miso),
        .SS_n   (ss_n),
        .SCLK   (sclk),
        .MOSI   (mosi),
        .batt   (batt),
        .curr   (curr),
        .brake  (brake),
        .torque (torque)
    );

    always #5 clk = ~clk;

    // ADC model state and timing statistics
    logic [15:0] adc_val [8];
    logic [15:0] cmd_q [$];
    int          conv_cnt = 0;
    int          frame_cnt = 0;
    int          rise_bad = 0;
    int          period_bad = 0;
    int          mosi_bad = 0;
    int          gap_bad = 0;
    int          gap_checks = 0;
    int          idle_bad = 0;
    bit          is_read = 1'b0;
    logic [2:0]  last_ch = 3'd0;
    int          cur_rise = 0;
    int          since_rise = 0;
    int          hi_cnt = 0;
    logic [15:0] shift_word = 16'h0;
    logic [15:0] rx_word = 16'h0;
    logic        prev_ss = 1'b1;
    logic        prev_sclk = 1'b1;
    logic        prev_mosi = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            is_read   = 1'b0;
            cur_rise  = 0;
            hi_cnt    = 0;
            miso      = 1'b0;
            prev_ss   = 1'b1;
            prev_sclk = 1'b1;
            prev_mosi = 1'b0;
        end else begin
            if (prev_ss && !ss_n) begin
                if (is_read) begin
                    gap_checks++;
                    if (hi_cnt != 1) gap_bad++;
                end
                cur_rise   = 0;
                since_rise = 0;
                rx_word    = 16'h0;
                shift_word = is_read ? adc_val[last_ch] : 16'h0000;
                miso       = shift_word[15];
            end else if (!prev_ss && !ss_n) begin
                since_rise++;
                if (!prev_sclk && sclk) begin
                    if (cur_rise > 0 && since_rise != 32) period_bad++;
                    rx_word    = {rx_word[14:0], mosi};
                    cur_rise++;
                    since_rise = 0;
                end
                if (prev_sclk && !sclk && cur_rise > 0) begin
                    shift_word = {shift_word[14:0], 1'b0};
                    miso       = shift_word[15];
                end
                if (mosi !== prev_mosi && !(prev_sclk && !sclk)) mosi_bad++;
            end else if (!prev_ss && ss_n) begin
                if (cur_rise != 16) rise_bad++;
                if (!sclk) idle_bad++;
                frame_cnt++;
                if (!is_read) begin
                    cmd_q.push_back(rx_word);
                    last_ch = rx_word[13:11];
                end else begin
                    conv_cnt++;
                end
                is_read = !is_read;
                hi_cnt  = 1;
            end else begin
                hi_cnt++;
                if (!sclk) idle_bad++;
            end
            prev_ss   = ss_n;
            prev_sclk = sclk;
            prev_mosi = mosi;
        end
    end

    task automatic wait_conv(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #2;
            if (conv_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_cmd(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #2;
            if (cmd_q.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int  n;
        bit  found;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if ({batt, curr, brake, torque} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_regs: got %h %h %h %h, expected all 000", batt, curr, brake, torque);
        end
        n_checks++;
        if ({ss_n, sclk, mosi} !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_spi: got SS_n=%b SCLK=%b MOSI=%b, expected 1 1 0", ss_n, sclk, mosi);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (ss_n === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found || n != 257) begin
            n_fail++;
            $display("FAIL first_ss_fall: got %0d clks (found=%0b), expected 257", n, found);
        end
        $display("reset: first SS_n fall after %0d clks", n);
    endtask

    task automatic test_single_channel();
        bit ok;
        adc_val[0] = 16'h0A5C;
        wait_conv(1, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL conv1_timeout: conversions=%0d, expected 1", conv_cnt);
        end
        n_checks++;
        if (cmd_q.size() < 1 || cmd_q[0] !== 16'h0000) begin
            n_fail++;
            $display("FAIL cmd0_word: got %h (queue %0d), expected 0000",
                     (cmd_q.size() > 0) ? cmd_q[0] : 16'hxxxx, cmd_q.size());
        end
        n_checks++;
        if (batt !== 12'hA5C) begin
            n_fail++;
            $display("FAIL batt_a5c: got %h, expected a5c", batt);
        end
        n_checks++;
        if ({curr, brake, torque} !== 36'h0) begin
            n_fail++;
            $display("FAIL others_hold0: got %h %h %h, expected 000 000 000", curr, brake, torque);
        end
        $display("conv 1: cmd=%h batt=%h curr=%h brake=%h torque=%h", cmd_q[0], batt, curr, brake, torque);
    endtask

    task automatic test_all_channels();
        bit          ok;
        logic [15:0] cmd_exp [4] = '{16'h0800, 16'h1800, 16'h2000, 16'h0000};
        logic [11:0] exp_b [4]   = '{12'hA5C, 12'hA5C, 12'hA5C, 12'h111};
        logic [11:0] exp_c [4]   = '{12'h222, 12'h222, 12'h222, 12'h222};
        logic [11:0] exp_k [4]   = '{12'h000, 12'h333, 12'h333, 12'h333};
        logic [11:0] exp_t [4]   = '{12'h000, 12'h000, 12'h444, 12'h444};
        adc_val[0] = 16'h0111;
        adc_val[1] = 16'h0222;
        adc_val[2] = 16'h0555;
        adc_val[3] = 16'h0333;
        adc_val[4] = 16'h0444;
        for (int k = 0; k < 4; k++) begin
            wait_conv(2 + k, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL conv%0d_timeout: conversions=%0d", 2 + k, conv_cnt);
            end
            n_checks++;
            if (cmd_q.size() < 2 + k || cmd_q[1 + k] !== cmd_exp[k]) begin
                n_fail++;
                $display("FAIL cmd%0d_word: got %h, expected %h", 1 + k,
                         (cmd_q.size() > 1 + k) ? cmd_q[1 + k] : 16'hxxxx, cmd_exp[k]);
            end
            n_checks++;
            if (batt !== exp_b[k] || curr !== exp_c[k] || brake !== exp_k[k] || torque !== exp_t[k]) begin
                n_fail++;
                $display("FAIL regs_after_conv%0d: got %h %h %h %h, expected %h %h %h %h", 2 + k,
                         batt, curr, brake, torque, exp_b[k], exp_c[k], exp_k[k], exp_t[k]);
            end
            $display("conv %0d: cmd=%h batt=%h curr=%h brake=%h torque=%h", 2 + k,
                     cmd_exp[k], batt, curr, brake, torque);
        end
    endtask

    task automatic test_upper_nibble();
        bit ok;
        adc_val[1] = 16'hF123;
        wait_conv(6, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL conv6_timeout: conversions=%0d", conv_cnt);
        end
        n_checks++;
        if (curr !== 12'h123) begin
            n_fail++;
            $display("FAIL curr_nibble: got %h, expected 123", curr);
        end
        n_checks++;
        if ({batt, brake, torque} !== {12'h111, 12'h333, 12'h444}) begin
            n_fail++;
            $display("FAIL hold_nibble: got %h %h %h, expected 111 333 444", batt, brake, torque);
        end
        $display("conv 6: batt=%h curr=%h brake=%h torque=%h", batt, curr, brake, torque);
    endtask

    task automatic test_spi_timing();
        n_checks++;
        if (rise_bad != 0) begin
            n_fail++;
            $display("FAIL sclk_rises: %0d frames without 16 rises, expected 0", rise_bad);
        end
        n_checks++;
        if (period_bad != 0) begin
            n_fail++;
            $display("FAIL sclk_period: %0d periods not 32 clks, expected 0", period_bad);
        end
        n_checks++;
        if (mosi_bad != 0) begin
            n_fail++;
            $display("FAIL mosi_edge: %0d MOSI changes off SCLK fall, expected 0", mosi_bad);
        end
        n_checks++;
        if (gap_bad != 0 || gap_checks == 0) begin
            n_fail++;
            $display("FAIL ss_gap: %0d of %0d gaps not 1 clk, expected 0 of >0", gap_bad, gap_checks);
        end
        n_checks++;
        if (idle_bad != 0) begin
            n_fail++;
            $display("FAIL sclk_idle: %0d idle clks with SCLK low, expected 0", idle_bad);
        end
        n_checks++;
        if (frame_cnt != 2 * conv_cnt) begin
            n_fail++;
            $display("FAIL frame_count: got %0d frames, expected %0d", frame_cnt, 2 * conv_cnt);
        end
        $display("timing: frames=%0d gaps=%0d", frame_cnt, gap_checks);
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        bit found;
        int base;
        int qs;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({batt, curr, brake, torque} !== 48'h0) begin
            n_fail++;
            $display("FAIL rereset_regs: got %h %h %h %h, expected all 000", batt, curr, brake, torque);
        end
        rst_n = 1'b1;
        adc_val[4] = 16'h0999;
        base = conv_cnt;
        wait_conv(base + 3, ok);
        n_checks++;
        if (!ok || {batt, curr, brake, torque} !== {12'h111, 12'h123, 12'h333, 12'h000}) begin
            n_fail++;
            $display("FAIL pre_abort_regs: got %h %h %h %h (ok=%0b), expected 111 123 333 000",
                     batt, curr, brake, torque, ok);
        end
        found = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #2;
            if (is_read && last_ch == 3'd4 && cur_rise == 9) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found || ss_n !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_point: found=%0b SS_n=%b, expected 1 0", found, ss_n);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ss_n !== 1'b1 || sclk !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_ss: got SS_n=%b SCLK=%b, expected 1 1", ss_n, sclk);
        end
        n_checks++;
        if (torque !== 12'h000) begin
            n_fail++;
            $display("FAIL abort_torque: got %h, expected 000", torque);
        end
        repeat (2) @(negedge clk);
        qs = cmd_q.size();
        base = conv_cnt;
        rst_n = 1'b1;
        wait_cmd(qs + 1, ok);
        n_checks++;
        if (!ok || cmd_q[qs] !== 16'h0000) begin
            n_fail++;
            $display("FAIL post_abort_cmd: got %h (ok=%0b), expected 0000",
                     (cmd_q.size() > qs) ? cmd_q[qs] : 16'hxxxx, ok);
        end
        wait_conv(base + 1, ok);
        n_checks++;
        if (!ok || batt !== 12'h111 || torque !== 12'h000) begin
            n_fail++;
            $display("FAIL post_abort_regs: got batt=%h torque=%h (ok=%0b), expected 111 000", batt, torque, ok);
        end
        $display("abort: post-reset batt=%h torque=%h", batt, torque);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) adc_val[i] = 16'h0000;
        test_reset();
        test_single_channel();
        test_all_channels();
        test_upper_nibble();
        test_spi_timing();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
